// File: rtl/irq_controller_if.sv
// Interrupt controller bus: device lines, CPU register port and the CPU interrupt handshake.
// The master side (devices and CPU) drives the stimulus; the slave side is the controller.
interface irq_controller_if #(
   parameter int N_IRQ = 4,
   parameter int CW    = 2
);
   logic [N_IRQ-1:0] irq_in;
   logic             reg_we;
   logic [1:0]       reg_sel;
   logic [N_IRQ-1:0] reg_wdata;
   logic [N_IRQ-1:0] reg_rdata;
   logic             int_ack;
   logic             int_ret;
   logic             int_req;
   logic [CW-1:0]    int_cause;
   logic             global_int_en;
   logic             in_service;

   modport master (
      output irq_in, reg_we, reg_sel, reg_wdata, int_ack, int_ret,
      input  reg_rdata, int_req, int_cause, global_int_en, in_service
   );

   modport slave (
      input  irq_in, reg_we, reg_sel, reg_wdata, int_ack, int_ret,
      output reg_rdata, int_req, int_cause, global_int_en, in_service
   );
endinterface

// File: rtl/irq_controller.sv
// Edge-captured, fixed-priority interrupt controller: pending is set one edge after a rising edge
// and int_req follows one edge later; the request is held until int_ack, and service ends on int_ret.
module irq_controller #(
   parameter int N_IRQ = 4,
   parameter int CW    = 2
) (
   input logic            clk,
   input logic            clr,
   irq_controller_if.slave bus
);
   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;

   state_e           state_q, state_d;
   logic [N_IRQ-1:0] irq_d_q;
   logic [N_IRQ-1:0] pending_q, pending_d;
   logic [N_IRQ-1:0] mask_q, mask_d;
   logic             gie_q, gie_d;
   logic [CW-1:0]    cause_q, cause_d;

   logic [N_IRQ-1:0] rise;
   logic [N_IRQ-1:0] active;
   logic [N_IRQ-1:0] w1c_bits;
   logic [N_IRQ-1:0] ack_bits;
   logic [CW-1:0]    first_idx;
   logic             ack_fire;
   logic             ret_fire;

   assign rise     = bus.irq_in & ~irq_d_q;
   assign active   = pending_q & mask_q;
   assign ack_fire = (state_q == REQ) && bus.int_ack;
   assign ret_fire = (state_q == SERVICE) && bus.int_ret;
   assign w1c_bits = (bus.reg_we && bus.reg_sel == 2'd1) ? bus.reg_wdata : '0;
   assign ack_bits = ack_fire ? (N_IRQ'(1) << cause_q) : '0;

   // Scan downward so the lowest set index is the one left standing.
   always_comb begin
      first_idx = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (active[i]) first_idx = CW'(i);
      end
   end

   always_comb begin
      pending_d = (pending_q & ~(w1c_bits | ack_bits)) | rise;
      mask_d    = mask_q;
      if (bus.reg_we && bus.reg_sel == 2'd0) mask_d = bus.reg_wdata;
   end

   // The handshake overrides software writes to gie; int_ret has the last word.
   always_comb begin
      gie_d = gie_q;
      if (bus.reg_we && bus.reg_sel == 2'd2) gie_d = bus.reg_wdata[0];
      if (ack_fire) gie_d = 1'b0;
      if (ret_fire) gie_d = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      case (state_q)
         IDLE: begin
            if (gie_q && (|active)) begin
               state_d = REQ;
               cause_d = first_idx;
            end
         end
         REQ: begin
            if (bus.int_ack) state_d = SERVICE;
         end
         SERVICE: begin
            if (bus.int_ret) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q   <= IDLE;
         irq_d_q   <= '0;
         pending_q <= '0;
         mask_q    <= '0;
         gie_q     <= 1'b0;
         cause_q   <= '0;
      end else begin
         state_q   <= state_d;
         irq_d_q   <= bus.irq_in;
         pending_q <= pending_d;
         mask_q    <= mask_d;
         gie_q     <= gie_d;
         cause_q   <= cause_d;
      end
   end

   always_comb begin
      bus.reg_rdata = '0;
      case (bus.reg_sel)
         2'd0:    bus.reg_rdata = mask_q;
         2'd1:    bus.reg_rdata = pending_q;
         2'd2:    bus.reg_rdata = {{(N_IRQ - 1){1'b0}}, gie_q};
         default: bus.reg_rdata = '0;
      endcase
   end

   assign bus.int_req       = (state_q == REQ);
   assign bus.int_cause     = cause_q;
   assign bus.global_int_en = gie_q;
   assign bus.in_service    = (state_q == SERVICE);
endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter N_IRQ, default 4: number of interrupt source lines; the legal range is 2..8.
REQ-002 Parameter CW, default 2: width of int_cause; the value SHALL equal ceil(log2(N_IRQ)).
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 clr  input  1  reset, asynchronous, active-high.
REQ-005 irq_in  input  N_IRQ  level interrupt lines from devices in the clk domain (e.g. timer irq_pin); index 0 is highest priority.
REQ-006 reg_we  input  1  register write strobe.
REQ-007 reg_sel  input  2  register select: 0 = mask, 1 = pending (write-1-to-clear), 2 = global enable (bit 0), 3 = reserved.
REQ-008 reg_wdata  input  N_IRQ  write data.
REQ-009 reg_rdata  output  N_IRQ  combinational read of the register at reg_sel; sel 2 returns {0, gie}; sel 3 returns 0.
REQ-010 int_ack  input  1  CPU has taken the presented interrupt; single-cycle pulse.
REQ-011 int_ret  input  1  CPU has executed interrupt return; single-cycle pulse.
REQ-012 int_req  output  1  interrupt request to the CPU.
REQ-013 int_cause  output  CW  index of the requested or in-service source.
REQ-014 global_int_en  output  1  current gie bit, fanned out to the devices.
REQ-015 in_service  output  1  high while the state is SERVICE.

Function
REQ-016 Edge capture: the block SHALL keep irq_d, which is irq_in registered each cycle; a rising edge is irq_in & ~irq_d.
REQ-017 pending[i] SHALL set on the edge after which a rising edge is seen on bit i, independent of mask and gie.
REQ-018 Per bit, a set event SHALL win over any simultaneous clear (ack or write-1-clear).
REQ-019 A level held high SHALL set pending only once; it SHALL NOT re-set after being cleared while the level is still high.
REQ-020 The state machine SHALL have three states: IDLE, REQ and SERVICE.
REQ-021 IDLE: if gie=1 and (pending & mask) is nonzero, move to REQ and latch cause = lowest set index of pending & mask.
REQ-022 REQ: int_req=1 and int_cause is held stable.
REQ-023 REQ: on int_ack, move to SERVICE, clear pending[cause] and clear gie in the same edge.
REQ-024 REQ SHALL NOT be withdrawn by a later mask, pending or gie write; it is left only via int_ack.
REQ-025 SERVICE: int_req=0 and int_cause holds the serviced index.
REQ-026 SERVICE: on int_ret, move to IDLE and set gie=1.
REQ-027 int_ack outside REQ and int_ret outside SERVICE SHALL be ignored.
REQ-028 Latency: irq_in rises before edge k -> pending set after edge k -> int_req high after edge k+1, provided state was IDLE, gie=1 and mask bit set.
REQ-029 Priority SHALL be evaluated only on the IDLE->REQ transition; a higher-priority arrival during REQ or SERVICE waits.
REQ-030 After int_ret with pending & mask still nonzero, int_req SHALL reassert one cycle after the return to IDLE.
REQ-031 Register writes take effect on the write edge.
REQ-032 A write to sel 2 in SERVICE SHALL update gie but SHALL NOT change state.
REQ-033 An int_ret and a gie write in the same cycle: int_ret wins (gie=1).
REQ-034 Bits of reg_wdata above N_IRQ and writes to sel 3 SHALL be ignored.

Reset
REQ-035 While clr=1: state=IDLE, pending=0, mask=0, gie=0, irq_d=0, cause=0.
REQ-036 Outputs during reset: int_req=0, int_cause=0, global_int_en=0, in_service=0.
REQ-037 Reset asserted mid-REQ or mid-SERVICE SHALL abort immediately, with no ack or ret required.
REQ-038 A line already high when clr deasserts SHALL register as an edge on the first clock edge after reset.

Verification
REQ-039 Setup mask=0b1111, gie=1; pulse irq_in[2] for 1 cycle at edge k -> int_req=1 after k+1, int_cause=2; int_ack -> pending=0b0000, global_int_en=0, in_service=1; int_ret -> global_int_en=1, IDLE.
REQ-040 irq_in[3] and irq_in[1] rise in the same cycle -> cause=1; after ack/ret, int_req reasserts with cause=3 one cycle after IDLE.
REQ-041 mask=0b1110, irq_in[0] rises -> pending=0b0001, no int_req; write mask=0b1111 -> int_req with cause=0 one cycle later.
REQ-042 Hold irq_in[1] high 20 cycles across ack/ret -> exactly one request; write-1-clear to sel 1 in the same cycle as a new edge on that bit -> pending bit stays 1.
REQ-043 Assert clr while in SERVICE -> all outputs 0 at once; irq_in[2] high at deassertion -> pending[2]=1 after the first edge.
REQ-044 int_ack in IDLE and int_ret in REQ -> no state or register change.
